// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO draining one frame at a time into uart_tx; optional level port under `UART_TX_FEEDER_LEVEL_EN.
// Latency: write at cycle N into an idle, empty feeder -> tx_trigger high in N+2; 2-cycle gap after tx_busy falls.
// Backpressure: writes while full are dropped and set sticky overflow; tx_busy high in IDLE holds off the pop.
module uart_tx_feeder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              tx_trigger,
    output logic [7:0]        tx_data,
    input  logic              tx_busy
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count;
    logic [ADDR_W:0]     count_nxt;
    logic                push;
    logic                pop;

    // full is the registered flag, so a write alongside a pop from a full FIFO is still refused
    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && !empty && !tx_busy;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (ADDR_W+1)'(1);
            2'b01:   count_nxt = count - (ADDR_W+1)'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
            // a rejected write outranks a simultaneous clear
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_trigger <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data    <= mem[rd_ptr];
                        tx_trigger <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_trigger <= 1'b0;
                    state      <= WAIT_BUSY;
                end
                // uart_tx raises busy the cycle after it samples trigger
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_trigger <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign level = count;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small uart_tx model (BAUD_DIV=4, 10-bit frames, busy 40 cycles).
`timescale 1ns/1ps
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       wr_en    = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       clr_ovf  = 1'b0;
    logic       tb_busy  = 1'b0;
    logic       model_en = 1'b1;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       tx_trigger;
    logic [7:0] tx_data;
    logic       tx_busy;
`ifdef UART_TX_FEEDER_LEVEL_EN
    logic [ADDR_W:0] level;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .tx_trigger (tx_trigger),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy)
`ifdef UART_TX_FEEDER_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    // uart_tx model: samples trigger while idle, busy from the next cycle for 10 bits x 4 cycles
    logic       m_busy;
    logic [9:0] m_sh;
    logic [1:0] m_cnt;
    logic [3:0] m_bit;
    logic       line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_sh   <= '1;
            m_cnt  <= 2'd0;
            m_bit  <= 4'd0;
        end else if (!m_busy) begin
            if (model_en && tx_trigger) begin
                m_busy <= 1'b1;
                m_sh   <= {1'b1, tx_data, 1'b0};
                m_cnt  <= 2'd0;
                m_bit  <= 4'd0;
            end
        end else if (m_cnt == 2'd3) begin
            m_cnt <= 2'd0;
            m_sh  <= {1'b1, m_sh[9:1]};
            if (m_bit == 4'd9) m_busy <= 1'b0;
            else               m_bit  <= m_bit + 4'd1;
        end else begin
            m_cnt <= m_cnt + 2'd1;
        end
    end

    assign tx_busy = m_busy | tb_busy;
    assign line    = m_busy ? m_sh[0] : 1'b1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: trigger pulses, model busy edges and serial line history, sampled at negedge
    int         n_trig = 0, n_fall = 0, n_rise = 0, n_wide = 0;
    int         trig_cyc [64];
    logic [7:0] trig_dat [64];
    logic       trig_empty [64];
    int         rise_cyc [64];
    int         fall_cyc [64];
    logic [7:0] fall_dat [64];
    logic       hist [8192];
    logic       prev_trig = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (cyc < 8192) hist[cyc] = line;
        if (tx_trigger) begin
            if (n_trig < 64) begin
                trig_cyc[n_trig]   = cyc;
                trig_dat[n_trig]   = tx_data;
                trig_empty[n_trig] = empty;
            end
            if (prev_trig) n_wide++;
            n_trig++;
        end
        if (m_busy && !prev_busy && n_rise < 64) begin
            rise_cyc[n_rise] = cyc;
            n_rise++;
        end
        if (!m_busy && prev_busy && n_fall < 64) begin
            fall_cyc[n_fall] = cyc;
            fall_dat[n_fall] = tx_data;
            n_fall++;
        end
        prev_trig = tx_trigger;
        prev_busy = m_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr1(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_trig(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_trig < target; i++) step();
        check(tag, 32'(n_trig >= target), 32'd1);
    endtask

    task automatic wait_fall(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && n_fall < target; i++) step();
        check(tag, 32'(n_fall >= target), 32'd1);
    endtask

    initial begin
        int w, bt, bf, nt, s;
        logic [9:0] v0, v3;

        // reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_flags", {full, empty, overflow, tx_trigger}, 4'b0100);
        check("rst_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) step();
        check("post_rst_flags", {full, empty, overflow, tx_trigger}, 4'b0100);
`ifdef UART_TX_FEEDER_LEVEL_EN
        check("level_rst", level, 5'd0);
`endif

        // single byte A5: trigger two cycles after the write, 40-cycle frame
        w = cyc;
        wr1(8'hA5);
        wait_trig(1, 20, "t1_trig_seen");
        check("t1_trig_cyc", trig_cyc[0], w + 2);
        check("t1_trig_dat", trig_dat[0], 8'hA5);
        wait_fall(1, 100, "t1_frame_done");
        check("t1_rise_cyc", rise_cyc[0], trig_cyc[0] + 1);
        check("t1_busy_len", fall_cyc[0] - rise_cyc[0], 40);
        s = rise_cyc[0];
        for (int i = 0; i < 10; i++) begin
            v0[i] = hist[s + 4*i];
            v3[i] = hist[s + 4*i + 3];
        end
        check("t1_line_bit_start", v0, 10'b1101001010);
        check("t1_line_bit_end", v3, 10'b1101001010);
        check("t1_empty", empty, 1'b1);
        repeat (2) step();

        // burst 01..05 back to back
        bt = n_trig;
        bf = n_fall;
        for (int i = 1; i <= 5; i++) wr1(8'(i));
        wait_fall(bf + 5, 400, "t2_frames_done");
        for (int k = 0; k < 5; k++) begin
            check("t2_dat", trig_dat[bt + k], 8'(k + 1));
            check("t2_empty_at_pop", trig_empty[bt + k], (k == 4) ? 1'b1 : 1'b0);
            check("t2_dat_held", fall_dat[bf + k], 8'(k + 1));
            if (k > 0) check("t2_gap", trig_cyc[bt + k], fall_cyc[bf + k - 1] + 2);
        end
        check("t2_trig_count", n_trig, bt + 5);
        repeat (3) step();

        // fill to full with busy held, 17th write overflows (set beats simultaneous clear)
        tb_busy = 1'b1;
        step();
        nt = n_trig;
        for (int i = 0; i < 16; i++) wr1(8'h10 + 8'(i));
        check("t3_full", full, 1'b1);
        check("t3_no_ovf_yet", overflow, 1'b0);
`ifdef UART_TX_FEEDER_LEVEL_EN
        check("t3_level_full", level, 5'd16);
`endif
        clr_ovf = 1'b1;
        wr1(8'h20);
        clr_ovf = 1'b0;
        check("t3_ovf_set_wins", overflow, 1'b1);
        check("t3_full_held", full, 1'b1);
        check("t3_no_pop_while_busy", n_trig, nt);
        tb_busy = 1'b0;
        bt = n_trig;
        bf = n_fall;
        wait_trig(bt + 16, 1000, "t3_drain_trig");
        wait_fall(bf + 16, 100, "t3_drain_done");
        for (int k = 0; k < 16; k++) check("t3_drain_dat", trig_dat[bt + k], 8'h10 + 8'(k));
        repeat (5) step();
        check("t3_dropped_byte_absent", n_trig, bt + 16);
        check("t3_empty", empty, 1'b1);
        check("t3_ovf_sticky", overflow, 1'b1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t3_ovf_cleared", overflow, 1'b0);

        // pop and write in the same cycle with 3 buffered, 20 times across the wrap
        model_en = 1'b0;
        tb_busy  = 1'b1;
        step();
        bt = n_trig;
        for (int i = 0; i < 3; i++) begin
            wr1(8'h40 + 8'(i));
`ifdef UART_TX_FEEDER_LEVEL_EN
            check("t4_level_fill", level, 5'(i + 1));
`endif
        end
        for (int i = 0; i < 20; i++) begin
            tb_busy = 1'b0;
            wr1(8'h43 + 8'(i));
            tb_busy = 1'b1;
            check("t4_flags_count3", {full, empty}, 2'b00);
`ifdef UART_TX_FEEDER_LEVEL_EN
            check("t4_level_steady", level, 5'd3);
`endif
            step();
            step();
            tb_busy = 1'b0;
            step();
        end
        for (int j = 0; j < 3; j++) begin
            tb_busy = 1'b0;
            step();
            tb_busy = 1'b1;
`ifdef UART_TX_FEEDER_LEVEL_EN
            check("t4_level_drain", level, 5'(2 - j));
`endif
            step();
            step();
            tb_busy = 1'b0;
            step();
        end
        check("t4_trig_count", n_trig, bt + 23);
        for (int k = 0; k < 23; k++) check("t4_order", trig_dat[bt + k], 8'h40 + 8'(k));
        check("t4_empty", empty, 1'b1);
        model_en = 1'b1;
        repeat (2) step();

        // asynchronous reset mid-frame with bytes queued
        bt = n_trig;
        for (int i = 0; i < 4; i++) wr1(8'h61 + 8'(i));
        wait_trig(bt + 1, 20, "t5_first_trig");
        repeat (10) step();
        check("t5_pre_rst_data", tx_data, 8'h61);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_flags", {full, empty, overflow, tx_trigger}, 4'b0100);
        check("t5_async_tx_data", tx_data, 8'h00);
        step();
        rst_n = 1'b1;
        nt = n_trig;
        repeat (60) step();
        check("t5_no_trig_after_rst", n_trig, nt);
        check("t5_empty", empty, 1'b1);
        w = cyc;
        wr1(8'h77);
        wait_trig(nt + 1, 20, "t5_new_trig");
        check("t5_new_trig_cyc", trig_cyc[nt], w + 2);
        check("t5_new_trig_dat", trig_dat[nt], 8'h77);
        check("trigger_single_cycle", n_wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers bytes from a system-side write port in a small FIFO and drains them one at a time into the downstream uart_tx byte transmitter.
- Drives uart_tx's trigger/data_in and monitors its busy output; enables back-to-back frames without the producer polling busy.
- Sits directly upstream of uart_tx; tx_trigger, tx_data and tx_busy connect 1:1 to trigger, data_in and busy.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock (50 MHz nominal)
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe; one byte per cycle when high
- wr_data  in  8  byte to enqueue
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- overflow  out  1  sticky: a write was attempted while full
- clr_ovf  in  1  clears overflow
- tx_trigger  out  1  one-cycle start pulse to uart_tx
- tx_data  out  8  byte to uart_tx; stable from pulse until next pop
- tx_busy  in  1  uart_tx busy

Behaviour:
- Reset is asynchronous on rst_n low: pointers 0, count 0, full=0, empty=1, overflow=0, tx_trigger=0, tx_data=8'h00, state=IDLE. Asserting reset mid-frame drops all buffered bytes. The downstream uart_tx shares rst_n.
- FIFO: circular buffer with rd_ptr/wr_ptr of ADDR_W bits (wrap DEPTH-1 -> 0) and a count of ADDR_W+1 bits. full/empty are registered from the count.
- Write: accepted when wr_en && !full. Memory is written at wr_ptr, then wr_ptr increments.
- Write while full: data is discarded, pointers do not change, overflow sets.
- overflow: clr_ovf clears it. If a set and a clear occur in the same cycle, the set wins.
- Pop and write in the same cycle: both take effect and count is unchanged. A write in the same cycle as a pop from a full FIFO is still rejected, because full is sampled before the pop.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty && !tx_busy, then tx_data <= mem[rd_ptr], rd_ptr++, count--, tx_trigger <= 1, go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_trigger <= 0, go to WAIT_BUSY. tx_trigger is therefore high for exactly the LAUNCH cycle.
  - WAIT_BUSY: when tx_busy=1, go to WAIT_DONE. This covers uart_tx asserting busy one cycle after it samples trigger.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency: a write in cycle N to an empty FIFO with the FSM in IDLE gives empty=0 at N+1, pop at the N+1 edge, and tx_trigger high during N+2.
- Inter-frame gap with the FIFO non-empty is 1 IDLE cycle + 1 LAUNCH cycle after busy falls. There is no gap within a burst beyond this.
- tx_data holds its value through LAUNCH/WAIT_*. It changes only on a pop.
- tx_busy high while in IDLE (foreign transmitter) holds off the pop.

Optional Feature:
- Macro UART_TX_FEEDER_LEVEL_EN.
- Defined: adds output port level, width ADDR_W+1, equal to the registered FIFO count (0..DEPTH). It updates in the same cycle as full/empty.
- Not defined: the port is absent. The count stays internal, and there is no other behavioural change.

Test Plan:
- Reset, then write 8'hA5 with uart_tx at BAUD_DIV=4 -> tx_trigger is one pulse 2 cycles after the write, tx_data=8'hA5, and the serial line shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, lasting 40 cycles.
- Burst-write 8'h01..8'h05 in 5 consecutive cycles -> 5 frames in order, each next trigger exactly 2 cycles after busy falls, empty=1 after the 5th pop.
- Write 17 bytes with DEPTH=16 while tx_busy is forced high -> full=1 after the 16th write, overflow=1 after the 17th, and the 16 stored bytes drain unchanged. Then clr_ovf -> overflow=0.
- Write and pop in the same cycle with 3 entries buffered -> count stays 3 and pointers wrap correctly over 20 iterations crossing DEPTH.
- rst_n low mid-frame with 4 bytes queued -> all outputs at reset values asynchronously, no trigger after release until a new write.
- With UART_TX_FEEDER_LEVEL_EN defined, write 3 then pop 1 -> level reads 0,1,2,3,2.
